// File: rtl/binary_decoder_scan.sv
// ============================================================================
//  Module   : binary_decoder_scan
//  Purpose  : Registered SEL_W-to-2**SEL_W one-hot decoder with enable, plus
//             an autonomous scan mode that walks the asserted output through
//             every position and holds each one for (dwell + 1) cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1        system clock, rising edge
//    rst    in   1        synchronous active-high reset
//    en     in   1        direct mode: decode enable; scan mode: run/pause
//    mode   in   1        0 = direct decode, 1 = scan (only looked at in IDLE)
//    sel    in   SEL_W    direct-mode select index
//    start  in   1        scan request, accepted in IDLE with mode = 1
//    dwell  in   DWELL_W  per-position hold count, captured on start
//    f      out  OUT_W    registered one-hot output (inverted if ACTIVE_LOW)
//    idx    out  SEL_W    index of the current position (0 when none)
//    valid  out  1        f carries an asserted bit
//    busy   out  1        scan in progress
//    done   out  1        one-cycle pulse after the last scan position
// ============================================================================
`default_nettype none

module binary_decoder_scan #(
    parameter int SEL_W      = 4,
    parameter int DWELL_W    = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    start,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(2**SEL_W)-1:0]   f,
    output logic [SEL_W-1:0]        idx,
    output logic                    valid,
    output logic                    busy,
    output logic                    done
);

    localparam int OUT_W = 2**SEL_W;

    // Value of f when nothing is asserted; also the XOR mask that applies
    // the output polarity to the positive-logic one-hot pattern.
    localparam logic [OUT_W-1:0] c_F_OFF    = {OUT_W{ACTIVE_LOW}};
    localparam logic [SEL_W-1:0] c_IDX_LAST = {SEL_W{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_idx;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   r_dwell;
    logic [OUT_W-1:0]     r_f;
    logic                 r_valid;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [SEL_W-1:0]     w_idx_nxt;
    logic [DWELL_W-1:0]   w_cnt_nxt;
    logic [DWELL_W-1:0]   w_dwell_nxt;
    logic                 w_assert;
    logic                 w_done_nxt;
    logic [OUT_W-1:0]     w_hot;
    logic [OUT_W-1:0]     w_f_nxt;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output register is loaded from
    // these values, so no input reaches f without passing through a flop.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_dwell_nxt = r_dwell;
        w_assert    = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!mode) begin
                    // Direct decode; start has no meaning here.
                    if (en) begin
                        w_idx_nxt = sel;
                        w_assert  = 1'b1;
                    end else begin
                        w_idx_nxt = '0;
                    end
                end else begin
                    w_idx_nxt = '0;
                    if (start) begin
                        // Bit 0 appears on the accepting edge, so the loaded
                        // count already covers the first displayed cycle.
                        w_state_nxt = S_SCAN;
                        w_dwell_nxt = dwell;
                        w_cnt_nxt   = dwell;
                        w_assert    = en;
                    end
                end
            end

            S_SCAN: begin
                // With en low everything holds and f goes dark (pause).
                if (en) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - DWELL_W'(1);
                        w_assert  = 1'b1;
                    end else if (r_idx != c_IDX_LAST) begin
                        w_idx_nxt = r_idx + SEL_W'(1);
                        w_cnt_nxt = r_dwell;
                        w_assert  = 1'b1;
                    end else begin
                        // Final position finished: no wrap, no restart.
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_hot            = '0;
        w_hot[w_idx_nxt] = 1'b1;
        w_f_nxt          = (w_assert ? w_hot : '0) ^ c_F_OFF;
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_f     <= c_F_OFF;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
            r_f     <= w_f_nxt;
            r_valid <= w_assert;
            r_done  <= w_done_nxt;
        end
    end

    assign f     = r_f;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign busy  = (r_state == S_SCAN);
    assign done  = r_done;

endmodule

`default_nettype wire

// File: doc/binary_decoder_scan.md
Name: binary_decoder_scan

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with enable. Generalises the combinational 4:16 decoder.
- Adds an autonomous scan mode that walks the active output through every position, holding each for a programmable dwell time.
- Used both as a clocked select decoder and as a self-test and lamp-walk sequencer driving one-hot loads.

Parameters:
- SEL_W, 4, select width; output width OUT_W = 2**SEL_W (localparam, not overridable).
- DWELL_W, 8, width of the dwell-count input.
- ACTIVE_LOW, 0, when 1 every bit of f is inverted at the output register (asserted = 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  enable; gates decoding in direct mode, pauses the scan in scan mode.
- mode  in  1  0 = direct decode, 1 = scan; sampled only in IDLE.
- sel  in  SEL_W  select index for direct mode.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE with mode=1.
- dwell  in  DWELL_W  hold count per output; sampled on accepted start.
- f  out  OUT_W  registered one-hot output (polarity per ACTIVE_LOW).
- idx  out  SEL_W  index of the currently asserted bit (0 when none).
- valid  out  1  high when f carries an asserted bit.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse after the final scan position completes.

Behaviour:
- Reset: synchronous on rst=1; overrides everything, including mid-scan. State=IDLE, idx=0, valid=0, busy=0, done=0, dwell counter=0. f=all-deasserted: 0 when ACTIVE_LOW=0, all-ones when ACTIVE_LOW=1.
- "Assert bit k" below means f[k]=1 and all others 0, inverted when ACTIVE_LOW=1.
- FSM has two states: IDLE and SCAN.
- IDLE, mode=0 (direct), 1-cycle latency:
  - If en=1, next edge asserts bit sel; idx=sel, valid=1.
  - If en=0, next edge deasserts f; valid=0, idx=0.
  - start is ignored.
- IDLE, mode=1: f is deasserted and valid=0.
  - start=1 (en is don't-care) -> SCAN. Latch dwell into dwell_r, idx=0, counter=dwell_r.
  - First edge after start asserts bit 0; valid=1 if en=1.
- SCAN, en=1:
  - Each cycle, if counter != 0 decrement it.
  - If counter == 0 and idx < OUT_W-1: idx+1, counter reloads dwell_r.
  - Result: each position is asserted for exactly dwell_r+1 cycles; dwell=0 gives one cycle per position.
- SCAN, en=0: pause. idx and counter freeze, f deasserted, valid=0, busy stays 1. Resuming en=1 continues the remaining dwell of the same idx.
- Scan end: when idx == OUT_W-1 and counter == 0 with en=1, the next edge sets state=IDLE, f deasserted, valid=0, idx=0, busy=0, done=1 for that one cycle.
- Total scan length with en held high is OUT_W*(dwell_r+1) cycles of valid, then the done pulse.
- During SCAN: start, mode, sel and dwell are all ignored. A start coincident with the final step is also ignored; no back-to-back restart.
- Simultaneous start and rst: rst wins.
- idx never exceeds OUT_W-1; no wrap-around inside a scan.
- All outputs are registered; no combinational path from any input to f.

Test Plan:
- Direct sweep: SEL_W=4, mode=0, en=1, sel=0..15, one per cycle -> one cycle later f=16'h0001, 16'h0002, ... 16'h8000; idx equals sel; valid=1. Then en=0 -> f=16'h0000, valid=0 next cycle.
- Scan with dwell=0: start pulse -> f walks 16'h0001 through 16'h8000 on 16 consecutive cycles, busy=1 throughout. done=1 on cycle 17, where f=0 and busy=0.
- Scan with dwell=2, pause: bit 5 is held for 3 cycles. Drop en for 4 cycles in the middle of idx=5 -> f=0, valid=0, idx stays 5, busy=1. Raise en -> bit 5 resumes for its remaining cycles. Total valid cycles = 48.
- Ignored inputs: during SCAN, toggle mode, sel, dwell and pulse start -> scan sequence and timing unchanged; exactly one done pulse.
- Reset mid-scan: rst=1 at idx=9 -> next edge f=0, idx=0, busy=0, valid=0, no done. A following start restarts from bit 0.
- ACTIVE_LOW=1, SEL_W=3: reset -> f=8'hFF. Direct sel=6, en=1 -> f=8'hBF.
